// File: rtl/iob_pkg.sv
// Shared types and constants for PDP-6 IO bus slave devices.
// Status bit positions use the bus numbering, where bit 35 is the LSB.
package iob_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    OFFER  = 2'd2
  } iob_state_e;

  localparam int unsigned ST_OVR  = 30;
  localparam int unsigned ST_BUSY = 31;
  localparam int unsigned ST_DONE = 32;
  localparam int unsigned ST_PIA  = 33;

  localparam logic [6:0] IOB_PTP = 7'o020;

endpackage

// File: rtl/iob_pia_decode.sv
// Turns a 3-bit PI assignment plus enable into a one-hot request on channels 1..7.
// Assignment 0 means "no channel", so it never produces a request.
module iob_pia_decode (
  input  logic [2:0] i_pia,
  input  logic       i_en,
  output logic [1:7] o_req
);

  always_comb begin
    o_req = '0;
    for (int unsigned i = 1; i <= 7; i++) begin
      o_req[i] = i_en && (i_pia == 3'(i));
    end
  end

endmodule

// File: rtl/iob_punch_dev.sv
// Byte-output slave on the PDP-6 IO bus: DATAO loads a byte that is offered to a sink after a
// fixed delay; on acceptance the device sets DONE and requests an interrupt on its PI channel.
module iob_punch_dev
  import iob_pkg::*;
#(
  parameter logic [6:0]  DEVCODE      = IOB_PTP,
  parameter int unsigned PUNCH_CYCLES = 1000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iob_poweron,
  input  logic        iob_reset,
  input  logic        datao_clear,
  input  logic        datao_set,
  input  logic        cono_clear,
  input  logic        cono_set,
  input  logic        iob_fm_datai,
  input  logic        iob_fm_status,
  input  logic        rdi_pulse,
  input  logic [3:9]  ios,
  input  logic [0:35] iob_write,
  output logic [1:7]  pi_req,
  output logic [0:35] iob_read,
  output logic        dr_split,
  output logic        rdi_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(PUNCH_CYCLES - 1);

  iob_state_e       r_state;
  logic [7:0]       r_buf;
  logic [2:0]       r_pia;
  logic             r_busy;
  logic             r_done;
  logic             r_ovr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic [1:7]       r_pi_req;

  logic       w_rst;
  logic       w_sel;
  logic       w_dc;
  logic       w_ds;
  logic       w_cc;
  logic       w_cs;
  logic       w_hs;
  logic       w_busy_base;
  logic       w_done_base;
  logic       w_busy_kept;
  logic       w_abort;
  logic       w_start;
  logic [7:0] w_buf_nx;
  logic       w_busy_nx;
  logic       w_done_nx;
  logic       w_ovr_nx;
  logic [2:0] w_pia_nx;
  logic [1:7] w_pi_req;
  logic       w_unused;

  assign w_rst = !reset || iob_reset || !iob_poweron;
  assign w_sel = (ios == DEVCODE);

  // DATAO is only honoured while idle; CONO always applies.
  assign w_dc = w_sel && datao_clear && !r_busy;
  assign w_ds = w_sel && datao_set && !r_busy;
  assign w_cc = w_sel && cono_clear;
  assign w_cs = w_sel && cono_set;
  assign w_hs = (r_state == OFFER) && out_ready;

  // Order of precedence: handshake/DATAO, then CONO clear, then CONO set.
  assign w_busy_base = w_ds ? 1'b1 : (w_hs ? 1'b0 : r_busy);
  assign w_done_base = w_ds ? 1'b0 : (w_hs ? 1'b1 : r_done);
  assign w_busy_kept = w_busy_base && !w_cc;
  assign w_abort     = w_cc && w_busy_base;
  assign w_start     = (w_ds && !w_cc) || (w_cs && iob_write[ST_BUSY] && !w_busy_kept);

  assign w_buf_nx  = (w_dc ? 8'd0 : r_buf) | (w_ds ? iob_write[28:35] : 8'd0);
  assign w_busy_nx = w_busy_kept || (w_cs && iob_write[ST_BUSY]);
  assign w_done_nx = (w_done_base && !w_cc) || (w_cs && iob_write[ST_DONE]);
  assign w_ovr_nx  = (r_ovr || (w_sel && datao_set && r_busy)) && !w_cc;
  assign w_pia_nx  = (w_cc ? 3'd0 : r_pia) | (w_cs ? iob_write[ST_PIA:ST_PIA+2] : 3'd0);

  iob_pia_decode u_pia_decode (
    .i_pia (r_pia),
    .i_en  (r_done),
    .o_req (w_pi_req)
  );

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_pia       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovr       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_pi_req    <= '0;
    end else begin
      r_buf    <= w_buf_nx;
      r_pia    <= w_pia_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_ovr    <= w_ovr_nx;
      r_pi_req <= w_pi_req;
      case (r_state)
        IDLE: ;
        TIMING: begin
          if (r_cnt == '0) begin
            r_state     <= OFFER;
            r_out_valid <= 1'b1;
            r_out_data  <= r_buf;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        OFFER: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_abort) begin
        r_state     <= IDLE;
        r_out_valid <= 1'b0;
      end
      // A restart in the same cycle as an abort begins a fresh transfer of the buffer.
      if (w_start) begin
        r_state <= TIMING;
        r_cnt   <= CntLoad;
      end
    end
  end

  always_comb begin
    iob_read = '0;
    if (w_sel && iob_fm_status) begin
      iob_read[ST_OVR]             = r_ovr;
      iob_read[ST_BUSY]            = r_busy;
      iob_read[ST_DONE]            = r_done;
      iob_read[ST_PIA:ST_PIA+2]    = r_pia;
    end
    if (w_sel && iob_fm_datai) begin
      iob_read[28:35] = iob_read[28:35] | r_buf;
    end
  end

  assign pi_req    = r_pi_req;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign dr_split  = 1'b0;
  assign rdi_data  = 1'b0;

  assign w_unused = ^{rdi_pulse, iob_write[0:27]};

endmodule
